// File: rtl/apb_cfg_slave_if.sv
// APB bus bundle between the host-side initiator and the configuration completer.
// The initiator drives address/control/write data; the completer returns read data and ready.
interface apb_cfg_slave_if #(
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 32
);
    logic [REG_ADDRWIDTH-1:0] PADDR;
    logic                     PWRITE;
    logic                     PSEL;
    logic                     PENABLE;
    logic [REG_DATAWIDTH-1:0] PWDATA;
    logic [REG_DATAWIDTH-1:0] PRDATA;
    logic                     PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_cfg_slave.sv
// Zero-wait-state APB completer for the matmul accelerator: configuration, start strobe,
// sticky status, interrupt and a busy-cycle counter.
module apb_cfg_slave #(
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 32,
    parameter int AWIDTH        = 10
) (
    input  logic              clk,
    input  logic              resetn,
    apb_cfg_slave_if.slave    apb,
    output logic              start_o,
    output logic              accum_en_o,
    output logic [AWIDTH-1:0] addr_a_o,
    output logic [AWIDTH-1:0] addr_b_o,
    output logic [AWIDTH-1:0] addr_c_o,
    output logic [7:0]        dim_m_o,
    output logic [7:0]        dim_n_o,
    output logic [7:0]        dim_k_o,
    input  logic              done_i,
    output logic              irq_o
);
    localparam logic [REG_ADDRWIDTH-1:0] OFF_CTRL   = REG_ADDRWIDTH'('h00);
    localparam logic [REG_ADDRWIDTH-1:0] OFF_STATUS = REG_ADDRWIDTH'('h04);
    localparam logic [REG_ADDRWIDTH-1:0] OFF_ADDR_A = REG_ADDRWIDTH'('h08);
    localparam logic [REG_ADDRWIDTH-1:0] OFF_ADDR_B = REG_ADDRWIDTH'('h0C);
    localparam logic [REG_ADDRWIDTH-1:0] OFF_ADDR_C = REG_ADDRWIDTH'('h10);
    localparam logic [REG_ADDRWIDTH-1:0] OFF_DIMS   = REG_ADDRWIDTH'('h14);
    localparam logic [REG_ADDRWIDTH-1:0] OFF_CYCLES = REG_ADDRWIDTH'('h18);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t                   r_state;
    logic                     r_pready;
    logic [REG_DATAWIDTH-1:0] r_prdata;
    logic                     r_accum;
    logic                     r_ie;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ign;
    logic                     r_start;
    logic [REG_DATAWIDTH-1:0] r_cycles;
    logic [23:0]              r_dims;

    logic                     w_setup;
    logic                     w_commit;
    logic                     w_wr_ctrl;
    logic                     w_wr_status;
    logic                     w_start_accept;
    logic                     w_start_ign;
    logic [REG_DATAWIDTH-1:0] w_rdata;
    logic                     w_unused_bits;

    // A setup phase is only recognised outside SETUP; PSEL&PENABLE seen in IDLE is dropped.
    assign w_setup  = apb.PSEL & ~apb.PENABLE & (r_state != ST_SETUP);
    assign w_commit = (r_state == ST_SETUP) & apb.PSEL & apb.PENABLE & r_pready & apb.PWRITE;

    assign w_wr_ctrl      = w_commit & (apb.PADDR == OFF_CTRL);
    assign w_wr_status    = w_commit & (apb.PADDR == OFF_STATUS);
    assign w_start_accept = w_wr_ctrl & apb.PWDATA[0] & ~r_busy;
    assign w_start_ign    = w_wr_ctrl & apb.PWDATA[0] & r_busy;
    assign w_unused_bits  = ^apb.PWDATA[REG_DATAWIDTH-1:24];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_pready <= 1'b0;
            r_prdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCESS: begin
                    if (w_setup) begin
                        r_state  <= ST_SETUP;
                        r_pready <= 1'b1;
                        if (!apb.PWRITE) begin
                            r_prdata <= w_rdata;
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        r_pready <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_state  <= ST_ACCESS;
                    r_pready <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_pready <= 1'b0;
                end
            endcase
        end
    end

    // Set events win over W1C clears, and an accepted start wins over a coincident done.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_accum  <= 1'b0;
            r_ie     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ign    <= 1'b0;
            r_start  <= 1'b0;
            r_cycles <= '0;
            r_dims   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_accum <= apb.PWDATA[1];
                r_ie    <= apb.PWDATA[2];
            end
            if (w_commit && (apb.PADDR == OFF_DIMS)) begin
                r_dims <= apb.PWDATA[23:0];
            end
            r_busy  <= w_start_accept | (r_busy & ~done_i);
            r_done  <= done_i | (r_done & ~(w_wr_status & apb.PWDATA[1]));
            r_ign   <= w_start_ign | (r_ign & ~(w_wr_status & apb.PWDATA[2]));
            r_start <= w_start_accept;
            if (w_start_accept) begin
                r_cycles <= '0;
            end else if (r_busy && (r_cycles != {REG_DATAWIDTH{1'b1}})) begin
                r_cycles <= r_cycles + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_addr
            localparam logic [REG_ADDRWIDTH-1:0] OFF = REG_ADDRWIDTH'(8 + 4 * gi);
            logic [AWIDTH-1:0] r_val;
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_val <= '0;
                end else if (w_commit && (apb.PADDR == OFF)) begin
                    r_val <= apb.PWDATA[AWIDTH-1:0];
                end
            end
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (apb.PADDR)
            OFF_CTRL:   w_rdata[2:0]        = {r_ie, r_accum, 1'b0};
            OFF_STATUS: w_rdata[2:0]        = {r_ign, r_done, r_busy};
            OFF_ADDR_A: w_rdata[AWIDTH-1:0] = g_addr[0].r_val;
            OFF_ADDR_B: w_rdata[AWIDTH-1:0] = g_addr[1].r_val;
            OFF_ADDR_C: w_rdata[AWIDTH-1:0] = g_addr[2].r_val;
            OFF_DIMS:   w_rdata[23:0]       = r_dims;
            OFF_CYCLES: w_rdata             = r_cycles;
            default:    w_rdata             = '0;
        endcase
    end

    assign apb.PREADY = r_pready;
    assign apb.PRDATA = r_prdata;
    assign start_o    = r_start;
    assign accum_en_o = r_accum;
    assign addr_a_o   = g_addr[0].r_val;
    assign addr_b_o   = g_addr[1].r_val;
    assign addr_c_o   = g_addr[2].r_val;
    assign dim_m_o    = r_dims[7:0];
    assign dim_n_o    = r_dims[15:8];
    assign dim_k_o    = r_dims[23:16];
    assign irq_o      = r_done & r_ie;
endmodule

// File: tb/tb_apb_cfg_slave.sv
// Directed plus randomized APB traffic against a register-map level model of the
// configuration completer; cycle counts are derived from edge timestamps.
module tb_apb_cfg_slave;
    logic       clk = 1'b0;
    logic       resetn;
    logic       start_o, accum_en_o, done_i, irq_o;
    logic [9:0] addr_a_o, addr_b_o, addr_c_o;
    logic [7:0] dim_m_o, dim_n_o, dim_k_o;

    apb_cfg_slave_if #(.REG_ADDRWIDTH(8), .REG_DATAWIDTH(32)) bus ();

    apb_cfg_slave #(.REG_ADDRWIDTH(8), .REG_DATAWIDTH(32), .AWIDTH(10)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .apb        (bus),
        .start_o    (start_o),
        .accum_en_o (accum_en_o),
        .addr_a_o   (addr_a_o),
        .addr_b_o   (addr_b_o),
        .addr_c_o   (addr_c_o),
        .dim_m_o    (dim_m_o),
        .dim_n_o    (dim_n_o),
        .dim_k_o    (dim_k_o),
        .done_i     (done_i),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int edge_cnt  = 0;
    int pulse_cnt = 0;
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (start_o === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    // Register-map model
    bit         m_accum, m_ie, m_busy, m_done, m_ign, m_started, m_ed_valid, m_last_accept;
    logic [9:0] m_addr [3];
    logic [23:0] m_dims;
    int         m_e0, m_ed, n_accept;

    logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h06};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_accum = 0; m_ie = 0; m_busy = 0; m_done = 0; m_ign = 0;
        m_started = 0; m_ed_valid = 0; m_last_accept = 0;
        for (int i = 0; i < 3; i++) m_addr[i] = '0;
        m_dims = '0; m_e0 = 0; m_ed = 0;
    endfunction

    // CYCLES after edge e = number of busy edges since the accepting edge
    function automatic logic [31:0] model_read(input logic [7:0] a, input int e);
        longint v;
        case (a)
            8'h00: return {29'd0, m_ie, m_accum, 1'b0};
            8'h04: return {29'd0, m_ign, m_done, m_busy};
            8'h08: return {22'd0, m_addr[0]};
            8'h0C: return {22'd0, m_addr[1]};
            8'h10: return {22'd0, m_addr[2]};
            8'h14: return {8'd0, m_dims};
            8'h18: begin
                if (!m_started) return 32'd0;
                v = longint'(m_ed_valid ? m_ed : e) - longint'(m_e0);
                if (v > longint'(32'hFFFF_FFFF)) v = longint'(32'hFFFF_FFFF);
                return v[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_done(input int c, input bit pre_busy);
        m_done = 1;
        if (pre_busy) begin
            m_busy = 0; m_ed = c; m_ed_valid = 1;
        end
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input int c, input bit dn);
        bit pre_busy;
        pre_busy = m_busy;
        m_last_accept = 0;
        case (a)
            8'h00: begin
                m_accum = d[1]; m_ie = d[2];
                if (d[0]) begin
                    if (!pre_busy) begin m_last_accept = 1; n_accept++; end
                    else m_ign = 1;
                end
            end
            8'h04: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_ign = 0;
            end
            8'h08: m_addr[0] = d[9:0];
            8'h0C: m_addr[1] = d[9:0];
            8'h10: m_addr[2] = d[9:0];
            8'h14: m_dims = d[23:0];
            default: ;
        endcase
        if (dn) model_done(c, pre_busy);
        if (m_last_accept) begin
            m_busy = 1; m_e0 = c; m_started = 1; m_ed_valid = 0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_addr"}, {2'b00, addr_c_o, addr_b_o, addr_a_o}, {2'b00, m_addr[2], m_addr[1], m_addr[0]});
        check({tag, "_dims"}, {8'd0, dim_k_o, dim_n_o, dim_m_o}, {8'd0, m_dims});
        check({tag, "_ctl"}, {29'd0, irq_o, accum_en_o, start_o}, {29'd0, m_done & m_ie, m_accum, m_last_accept});
    endtask

    // One APB transfer; keep_sel leaves PSEL high for a back-to-back follow-up.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit keep_sel, input bit dn);
        logic [31:0] exp;
        bit pre_busy;
        exp = model_read(a, edge_cnt);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
        @(posedge clk); #1;
        check("pready_setup", {31'd0, bus.PREADY}, 32'd1);
        if (!wr) check("prdata", bus.PRDATA, exp);
        bus.PENABLE = 1'b1;
        if (dn) done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        pre_busy = m_busy;
        if (wr) model_write(a, d, edge_cnt, dn);
        else begin
            m_last_accept = 0;
            if (dn) model_done(edge_cnt, pre_busy);
        end
        check("pready_access", {31'd0, bus.PREADY}, 32'd0);
        if (!wr) check("prdata_hold", bus.PRDATA, exp);
        check_outputs(wr ? "wr" : "rd");
        $display("apb %s addr=%02h data=%08h done=%0d", wr ? "WR" : "RD", a, wr ? d : bus.PRDATA, dn);
        bus.PENABLE = 1'b0;
        if (!keep_sel) bus.PSEL = 1'b0;
    endtask

    task automatic pulse_done();
        bit pre_busy;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        pre_busy = m_busy;
        m_last_accept = 0;
        model_done(edge_cnt, pre_busy);
        check("irq_after_done", {31'd0, irq_o}, {31'd0, m_ie});
        $display("core done pulse edge=%0d", edge_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_keep, keep, dn, wr;
        logic [7:0]  a;
        logic [31:0] d;

        n_accept = 0;
        model_reset();
        resetn = 1'b0; done_i = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus", {bus.PRDATA[30:0], bus.PREADY}, 32'd0);
        check_outputs("rst");
        resetn = 1'b1;
        idle(1);

        for (int i = 0; i < 7; i++) xfer(1'b0, 8'(4 * i), 32'd0, 1'b0, 1'b0);

        xfer(1'b1, 8'h08, 32'h0000_03FF, 1'b0, 1'b0);
        xfer(1'b1, 8'h14, 32'hAA0C_0804, 1'b0, 1'b0);
        xfer(1'b0, 8'h08, 32'd0, 1'b0, 1'b0);
        check("addr_a_lit", bus.PRDATA, 32'h0000_03FF);
        xfer(1'b0, 8'h14, 32'd0, 1'b0, 1'b0);
        check("dims_lit", bus.PRDATA, 32'h000C_0804);
        check("dims_out_lit", {8'd0, dim_k_o, dim_n_o, dim_m_o}, 32'h000C_0804);

        xfer(1'b1, 8'h00, 32'h5, 1'b0, 1'b0);
        xfer(1'b0, 8'h04, 32'd0, 1'b0, 1'b0);
        check("status_busy_lit", bus.PRDATA, 32'h1);
        while (edge_cnt < m_e0 + 19) idle(1);
        pulse_done();
        xfer(1'b0, 8'h04, 32'd0, 1'b0, 1'b0);
        check("status_done_lit", bus.PRDATA, 32'h2);
        check("irq_set", {31'd0, irq_o}, 32'd1);
        xfer(1'b0, 8'h18, 32'd0, 1'b0, 1'b0);
        check("cycles20", bus.PRDATA, 32'd20);
        xfer(1'b1, 8'h04, 32'h2, 1'b0, 1'b0);
        check("irq_clr", {31'd0, irq_o}, 32'd0);

        xfer(1'b1, 8'h00, 32'h5, 1'b0, 1'b0);
        xfer(1'b1, 8'h00, 32'h5, 1'b0, 1'b0);
        xfer(1'b0, 8'h04, 32'd0, 1'b0, 1'b0);
        check("status_ign_lit", bus.PRDATA, 32'h5);
        xfer(1'b1, 8'h04, 32'h4, 1'b0, 1'b1);
        xfer(1'b0, 8'h04, 32'd0, 1'b0, 1'b0);
        check("w1c_vs_done_lit", bus.PRDATA, 32'h2);

        xfer(1'b1, 8'h1C, 32'h1234_5678, 1'b0, 1'b0);
        xfer(1'b0, 8'h1C, 32'd0, 1'b0, 1'b0);
        xfer(1'b0, 8'h08, 32'd0, 1'b0, 1'b0);

        // PSEL with PENABLE already high while idle must be ignored
        idle(1);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 8'h08; bus.PWDATA = 32'h155;
        idle(1);
        check("viol_pready", {31'd0, bus.PREADY}, 32'd0);
        idle(1);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        idle(1);
        check("viol_addr_a", {22'd0, addr_a_o}, {22'd0, m_addr[0]});

        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h0C; bus.PWDATA = 32'h2AB;
        idle(1);
        bus.PENABLE = 1'b1; resetn = 1'b0;
        idle(1);
        model_reset();
        check("rst_mid_addr_b", {22'd0, addr_b_o}, 32'd0);
        check("rst_mid_pready", {31'd0, bus.PREADY}, 32'd0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; resetn = 1'b1;
        idle(1);
        xfer(1'b0, 8'h0C, 32'd0, 1'b0, 1'b0);

        xfer(1'b1, 8'h10, 32'h0000_0123, 1'b1, 1'b0);
        xfer(1'b0, 8'h10, 32'd0, 1'b1, 1'b0);
        xfer(1'b1, 8'h00, 32'h0000_0003, 1'b1, 1'b0);
        xfer(1'b0, 8'h04, 32'd0, 1'b1, 1'b0);
        xfer(1'b0, 8'h18, 32'd0, 1'b0, 1'b0);

        prev_keep = 1'b0;
        for (int it = 0; it < 120; it++) begin
            if (!prev_keep && $urandom_range(0, 4) == 0) begin
                pulse_done();
                idle($urandom_range(0, 2));
            end else begin
                a    = offs[$urandom_range(0, 9)];
                wr   = 1'($urandom_range(0, 1));
                d    = $urandom;
                keep = (it != 119) && ($urandom_range(0, 2) == 0);
                dn   = ($urandom_range(0, 7) == 0);
                xfer(wr, a, d, keep, dn);
                prev_keep = keep;
                if (!keep) idle($urandom_range(0, 3));
            end
        end

        idle(2);
        check("start_pulses", 32'(pulse_cnt), 32'(n_accept));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
